pipeline_control: RTL and testbench
===================================

# pipeline_control

Central stall, flush and forwarding controller for the five-stage pipeline. It consumes the destination-register and forward-eligibility signals produced by the hazard unit for the EX/MEM and MEM/WB latches. From these it drives the operand-forward mux selects, the per-latch enable and flush strobes, and the PC enable. A small state machine tracks data-memory wait, load-use bubbles and halt, and two performance counters record lost cycles.

## Interface
- `CNT_W`, default 32: width of the performance counters.
- `CLK` in 1: pipeline clock, rising edge.
- `nRST` in 1: synchronous reset, active low.
- `idex_rs`, `idex_rt` in 5 each: source registers of the instruction in the ID/EX latch.
- `ex_reg` in 5, `ex_forward` in 1, `ex_is_load` in 1: destination, write-eligibility and LW flag of the EX/MEM latch.
- `mem_reg` in 5, `mem_forward` in 1: destination and write-eligibility of the MEM/WB latch.
- `mem_dreq` in 1: EX/MEM holds a LW or SW.
- `dhit` in 1: data-memory access completes this cycle.
- `ihit` in 1: instruction fetch completes this cycle.
- `branch_taken` in 1: taken branch or jump resolved in EX.
- `wb_halt` in 1: HALT is present in MEM/WB.
- `fwd_a`, `fwd_b` out 2 each: operand selects. 00 = regfile, 01 = EX/MEM result, 10 = MEM/WB result.
- `pc_en`, `ifid_en`, `idex_en`, `exmem_en`, `memwb_en` out 1 each: latch enables.
- `ifid_flush`, `idex_flush`, `exmem_flush` out 1 each: load a bubble (all zeros) into the latch instead of its input.
- `halt` out 1: sticky, asserted once halted.
- `stall_cnt`, `bubble_cnt` out `CNT_W` each: count of frozen cycles and count of injected load-use bubbles.

## Operation
- **Forward A.** `fwd_a` is computed as follows; `fwd_b` is identical using `idex_rt`.
  - If `idex_rs` != 0 and `ex_forward` and !`ex_is_load` and `ex_reg` == `idex_rs`, then 01.
  - Else if `idex_rs` != 0 and `mem_forward` and `mem_reg` == `idex_rs`, then 10.
  - Else 00.
  - An EX/MEM match always beats a MEM/WB match.
- **Load-use (lu).** `ex_forward` & `ex_is_load` & (`ex_reg` == `idex_rs` & `idex_rs` != 0, or the same test on `idex_rt`).
- **FSM states.**
  - RUN.
  - DWAIT: entered when `mem_dreq` & !`dhit`. Stays while !`dhit`. Returns to RUN on the cycle `dhit` rises, and that cycle advances normally.
  - HALT: entered from any state when `wb_halt` is sampled 1. Absorbing; left only by reset.
- **Enables and flushes, in priority order:**
  - HALT, or reset low: all enables 0, all flushes 0, `fwd_*` = 00.
  - DWAIT, or (RUN & `mem_dreq` & !`dhit`): all enables 0. Freezes the whole pipe, including across a pending branch or lu.
  - lu: `pc_en` = `ifid_en` = `idex_en` = 0. `exmem_en` = `exmem_flush` = 1. `memwb_en` = 1.
  - `branch_taken`: all enables 1, and `ifid_flush` = `idex_flush` = 1. `pc_en` = 1 regardless of `ihit`.
  - !`ihit`: `pc_en` = 0, `ifid_en` = `ifid_flush` = 1, others enabled.
  - Otherwise: all enables 1, all flushes 0.
- **Counters.**
  - `stall_cnt` increments on every cycle in which `memwb_en` is 0 while the state is not HALT.
  - `bubble_cnt` increments on every cycle the lu row is active.
  - Both saturate at all-ones; they do not wrap.
- **Reset mid-operation.** Sampling `nRST` = 0 forces RUN, clears `halt` and both counters, and aborts any DWAIT.

## Timing
- `fwd_*`, enables and flushes are combinational from the inputs and state, with zero-cycle latency.
- State, `halt` and the counters update on the `CLK` rising edge.
- `halt` rises on the edge after `wb_halt` is first seen at 1. Enables are 0 starting that same following cycle.
- A load-use hazard costs exactly one bubble. On the next cycle the LW sits in MEM/WB and the consumer gets `fwd` = 10.
- DWAIT exit has zero extra cycles: the `dhit` cycle itself advances the pipe.

## Structure
- Shared `cpu_types_pkg` holds:
  - the `fwd_sel_t` enum (FWD_RF, FWD_EXMEM, FWD_MEMWB);
  - the `pc_state_t` enum (RUN, DWAIT, HALT);
  - `regbits_t`.
- Interface `pipeline_control_if` carries all ports except `CLK` and `nRST`.
- Sub-module `forward_sel`: a pure combinational single-operand selector, instantiated twice (rs and rt).

## Test plan
- **Forward priority.** `idex_rs` = 5, `ex_reg` = 5, `ex_forward` = 1, `mem_reg` = 5, `mem_forward` = 1 -> `fwd_a` = 01. Repeat with `idex_rs` = 0 -> `fwd_a` = 00.
- **Load-use.** `ex_is_load` = 1, `ex_reg` = 8, `idex_rt` = 8 -> one cycle with `pc_en` = 0 and `exmem_flush` = 1, and `bubble_cnt` goes 0 -> 1. Next cycle `mem_reg` = 8 -> `fwd_b` = 10.
- **DWAIT.** `mem_dreq` = 1 and `dhit` low for 3 cycles, with `branch_taken` = 1 -> all enables 0 for 3 cycles and no flush. `stall_cnt` = 3. The cycle `dhit` = 1 gives all enables 1 with `ifid_flush` = `idex_flush` = 1.
- **Icache miss.** `ihit` = 0 -> `pc_en` = 0 and `ifid_flush` = 1. Add `branch_taken` = 1 -> `pc_en` = 1.
- **Halt, then reset.**
  - `wb_halt` pulse -> `halt` = 1 on the next edge; enables stay 0 even with `wb_halt` back at 0.
  - `nRST` = 0 for one edge -> `halt` = 0, counters = 0, state RUN.
- **Saturation.** With `CNT_W` = 4, 20 stall cycles -> `stall_cnt` holds at 15.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Types shared by the pipeline control logic: register index, forward selects, and
// control states.
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    DWAIT = 2'b01,
    HALT  = 2'b10
  } pc_state_t;

endpackage

// File: rtl/pipeline_control_if.sv
// Bundle of every pipeline_control signal except clock and reset.
interface pipeline_control_if #(
  parameter int unsigned CNT_W = 32
);
  import cpu_types_pkg::*;

  regbits_t           idex_rs;
  regbits_t           idex_rt;
  regbits_t           ex_reg;
  logic               ex_forward;
  logic               ex_is_load;
  regbits_t           mem_reg;
  logic               mem_forward;
  logic               mem_dreq;
  logic               dhit;
  logic               ihit;
  logic               branch_taken;
  logic               wb_halt;
  logic [1:0]         fwd_a;
  logic [1:0]         fwd_b;
  logic               pc_en;
  logic               ifid_en;
  logic               idex_en;
  logic               exmem_en;
  logic               memwb_en;
  logic               ifid_flush;
  logic               idex_flush;
  logic               exmem_flush;
  logic               halt;
  logic [CNT_W-1:0]   stall_cnt;
  logic [CNT_W-1:0]   bubble_cnt;

endinterface

// File: rtl/forward_sel.sv
// Single-operand forward selector; also flags a load-use match on this operand.
module forward_sel
  import cpu_types_pkg::*;
(
  input  regbits_t src,
  input  regbits_t ex_reg,
  input  logic     ex_forward,
  input  logic     ex_is_load,
  input  regbits_t mem_reg,
  input  logic     mem_forward,
  output fwd_sel_t sel,
  output logic     load_hit
);

  logic live;
  assign live = (src != '0);

  always_comb begin
    sel = FWD_RF;
    if (live && ex_forward && !ex_is_load && (ex_reg == src)) begin
      sel = FWD_EXMEM;
    end else if (live && mem_forward && (mem_reg == src)) begin
      sel = FWD_MEMWB;
    end
  end

  // A load result is not ready in EX/MEM, so the consumer must wait a cycle.
  assign load_hit = live && ex_forward && ex_is_load && (ex_reg == src);

endmodule

// File: rtl/pipeline_control.sv
// Stall, flush and forwarding control for the five-stage pipeline, with memory-wait and
// halt tracking and saturating lost-cycle counters.
module pipeline_control
  import cpu_types_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  regbits_t         idex_rs,
  input  regbits_t         idex_rt,
  input  regbits_t         ex_reg,
  input  logic             ex_forward,
  input  logic             ex_is_load,
  input  regbits_t         mem_reg,
  input  logic             mem_forward,
  input  logic             mem_dreq,
  input  logic             dhit,
  input  logic             ihit,
  input  logic             branch_taken,
  input  logic             wb_halt,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  pc_state_t        state_q;
  logic             halt_q;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] bubble_q;

  fwd_sel_t sel_a;
  fwd_sel_t sel_b;
  logic     hit_a;
  logic     hit_b;

  forward_sel u_fwd_rs (
    .src         (idex_rs),
    .ex_reg      (ex_reg),
    .ex_forward  (ex_forward),
    .ex_is_load  (ex_is_load),
    .mem_reg     (mem_reg),
    .mem_forward (mem_forward),
    .sel         (sel_a),
    .load_hit    (hit_a)
  );

  forward_sel u_fwd_rt (
    .src         (idex_rt),
    .ex_reg      (ex_reg),
    .ex_forward  (ex_forward),
    .ex_is_load  (ex_is_load),
    .mem_reg     (mem_reg),
    .mem_forward (mem_forward),
    .sel         (sel_b),
    .load_hit    (hit_b)
  );

  logic active;
  logic mem_stall;
  logic load_use;
  logic bubble_row;

  assign active     = nRST && (state_q != HALT);
  // The dhit cycle of a wait advances normally, so the wait only freezes while !dhit.
  assign mem_stall  = !dhit && ((state_q == DWAIT) || ((state_q == RUN) && mem_dreq));
  assign load_use   = hit_a || hit_b;
  assign bubble_row = active && !mem_stall && load_use;

  always_comb begin
    fwd_a       = FWD_RF;
    fwd_b       = FWD_RF;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    if (active) begin
      fwd_a = sel_a;
      fwd_b = sel_b;
      if (mem_stall) begin
        // whole pipe frozen, pending branch or load-use waits it out
      end else if (load_use) begin
        exmem_en    = 1'b1;
        exmem_flush = 1'b1;
        memwb_en    = 1'b1;
      end else if (branch_taken) begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (!ihit) begin
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        ifid_flush = 1'b1;
      end else begin
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        idex_en  = 1'b1;
        exmem_en = 1'b1;
        memwb_en = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q  <= RUN;
      halt_q   <= 1'b0;
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (!memwb_en && (state_q != HALT) && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (bubble_row && (bubble_q != '1)) begin
        bubble_q <= bubble_q + CNT_W'(1);
      end
      if (wb_halt) begin
        state_q <= HALT;
        halt_q  <= 1'b1;
      end else begin
        unique case (state_q)
          RUN:     if (mem_dreq && !dhit) state_q <= DWAIT;
          DWAIT:   if (dhit) state_q <= RUN;
          HALT:    state_q <= HALT;
          default: state_q <= RUN;
        endcase
      end
    end
  end

  assign halt       = halt_q;
  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_pipeline_control.sv
// Directed bench for pipeline_control: a behavioural model checked every cycle plus
// hand-computed literal expectations.
module tb_pipeline_control;
  import cpu_types_pkg::*;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;
  localparam int NSIG = 13;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  pipeline_control_if #(.CNT_W(CW)) pif ();

  pipeline_control #(.CNT_W(CW)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .idex_rs      (pif.idex_rs),
    .idex_rt      (pif.idex_rt),
    .ex_reg       (pif.ex_reg),
    .ex_forward   (pif.ex_forward),
    .ex_is_load   (pif.ex_is_load),
    .mem_reg      (pif.mem_reg),
    .mem_forward  (pif.mem_forward),
    .mem_dreq     (pif.mem_dreq),
    .dhit         (pif.dhit),
    .ihit         (pif.ihit),
    .branch_taken (pif.branch_taken),
    .wb_halt      (pif.wb_halt),
    .fwd_a        (pif.fwd_a),
    .fwd_b        (pif.fwd_b),
    .pc_en        (pif.pc_en),
    .ifid_en      (pif.ifid_en),
    .idex_en      (pif.idex_en),
    .exmem_en     (pif.exmem_en),
    .memwb_en     (pif.memwb_en),
    .ifid_flush   (pif.ifid_flush),
    .idex_flush   (pif.idex_flush),
    .exmem_flush  (pif.exmem_flush),
    .halt         (pif.halt),
    .stall_cnt    (pif.stall_cnt),
    .bubble_cnt   (pif.bubble_cnt)
  );

  // Signal ids: 0 fwd_a, 1 fwd_b, 2..6 pc/ifid/idex/exmem/memwb en,
  // 7..9 ifid/idex/exmem flush, 10 halt, 11 stall_cnt, 12 bubble_cnt.
  localparam int S_FA = 0, S_FB = 1, S_PC = 2, S_IFID = 3, S_IDEX = 4, S_EXMEM = 5;
  localparam int S_MEMWB = 6, S_IFF = 7, S_IDF = 8, S_EXF = 9, S_HALT = 10;
  localparam int S_STALL = 11, S_BUB = 12;

  string sig_name [NSIG] = '{"fwd_a", "fwd_b", "pc_en", "ifid_en", "idex_en", "exmem_en",
                             "memwb_en", "ifid_flush", "idex_flush", "exmem_flush", "halt",
                             "stall_cnt", "bubble_cnt"};

  // Model state: halted, waiting on data memory, and the two counters.
  bit m_halt = 1'b0;
  bit m_wait = 1'b0;
  int m_stall = 0;
  int m_bub = 0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Literal expectations for the coming sample point; written only by the stimulus.
  string lit_name [16];
  int    lit_id   [16];
  int    lit_val  [16];
  int    lit_n = 0;

  function automatic int fwd_of(logic [4:0] src);
    if (src == 0) return 0;
    if (pif.ex_forward && !pif.ex_is_load && pif.ex_reg == src) return 1;
    if (pif.mem_forward && pif.mem_reg == src) return 2;
    return 0;
  endfunction

  function automatic bit ld_of(logic [4:0] src);
    return src != 0 && pif.ex_forward && pif.ex_is_load && pif.ex_reg == src;
  endfunction

  function automatic bit m_active();
    return nRST && !m_halt;
  endfunction

  function automatic bit m_frozen();
    return !pif.dhit && (m_wait || pif.mem_dreq);
  endfunction

  function automatic bit m_lu();
    return ld_of(pif.idex_rs) || ld_of(pif.idex_rt);
  endfunction

  // {pc, ifid, idex, exmem, memwb enables, ifid, idex, exmem flushes}
  function automatic logic [7:0] m_row();
    if (!m_active() || m_frozen()) return 8'b00000_000;
    if (m_lu())                     return 8'b00011_001;
    if (pif.branch_taken)           return 8'b11111_110;
    if (!pif.ihit)                  return 8'b01111_100;
    return 8'b11111_000;
  endfunction

  function automatic int model_out(int id);
    logic [7:0] r;
    r = m_row();
    case (id)
      S_FA:    return m_active() ? fwd_of(pif.idex_rs) : 0;
      S_FB:    return m_active() ? fwd_of(pif.idex_rt) : 0;
      S_HALT:  return int'(m_halt);
      S_STALL: return m_stall;
      S_BUB:   return m_bub;
      default: return int'(r[9-id]);
    endcase
  endfunction

  function automatic int dut_val(int id);
    case (id)
      S_FA:    return int'(pif.fwd_a);
      S_FB:    return int'(pif.fwd_b);
      S_PC:    return int'(pif.pc_en);
      S_IFID:  return int'(pif.ifid_en);
      S_IDEX:  return int'(pif.idex_en);
      S_EXMEM: return int'(pif.exmem_en);
      S_MEMWB: return int'(pif.memwb_en);
      S_IFF:   return int'(pif.ifid_flush);
      S_IDF:   return int'(pif.idex_flush);
      S_EXF:   return int'(pif.exmem_flush);
      S_HALT:  return int'(pif.halt);
      S_STALL: return int'(pif.stall_cnt);
      default: return int'(pif.bubble_cnt);
    endcase
  endfunction

  always @(posedge CLK) begin
    logic [7:0] r;
    bit bub;
    r   = m_row();
    bub = m_active() && !m_frozen() && m_lu();
    if (!nRST) begin
      m_halt = 1'b0; m_wait = 1'b0; m_stall = 0; m_bub = 0;
    end else begin
      if (!m_halt && !r[3] && m_stall < CMAX) m_stall++;
      if (bub && m_bub < CMAX) m_bub++;
      if (pif.wb_halt) m_halt = 1'b1;
      else if (!m_halt) m_wait = !pif.dhit && (m_wait || pif.mem_dreq);
    end
  end

  always @(negedge CLK) begin
    int a, e;
    cyc++;
    for (int i = 0; i < NSIG; i++) begin
      a = dut_val(i);
      e = model_out(i);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL model %s cycle %0d: got %0d expected %0d", sig_name[i], cyc, a, e);
      end
    end
    for (int i = 0; i < lit_n; i++) begin
      a = dut_val(lit_id[i]);
      checks++;
      if (a !== lit_val[i]) begin
        errors++;
        $display("FAIL %s (%s) cycle %0d: got %0d expected %0d", lit_name[i],
                 sig_name[lit_id[i]], cyc, a, lit_val[i]);
      end
    end
  end

  task automatic lit(input string nm, input int id, input int v);
    lit_name[lit_n] = nm;
    lit_id[lit_n]   = id;
    lit_val[lit_n]  = v;
    lit_n++;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    lit_n = 0;
  endtask

  task automatic idle_inputs();
    pif.idex_rs = '0; pif.idex_rt = '0; pif.ex_reg = '0; pif.ex_forward = 1'b0;
    pif.ex_is_load = 1'b0; pif.mem_reg = '0; pif.mem_forward = 1'b0;
    pif.mem_dreq = 1'b0; pif.dhit = 1'b0; pif.ihit = 1'b1;
    pif.branch_taken = 1'b0; pif.wb_halt = 1'b0;
  endtask

  initial begin
    nRST = 1'b0;
    idle_inputs();
    tick();

    // Reset: outputs gated even with a live forwarding match.
    pif.idex_rs = 5'd5; pif.ex_reg = 5'd5; pif.ex_forward = 1'b1;
    lit("reset fwd gated", S_FA, 0);
    lit("reset pc_en", S_PC, 0);
    lit("reset halt", S_HALT, 0);
    lit("reset stall_cnt", S_STALL, 0);
    tick();
    nRST = 1'b1;
    idle_inputs();
    lit("run pc_en", S_PC, 1);
    lit("run ifid_flush", S_IFF, 0);
    tick();

    // Forward priority.
    pif.idex_rs = 5'd5; pif.ex_reg = 5'd5; pif.ex_forward = 1'b1;
    pif.mem_reg = 5'd5; pif.mem_forward = 1'b1;
    lit("fwd exmem beats memwb", S_FA, 1);
    tick();
    pif.idex_rs = 5'd0; pif.ex_reg = 5'd0; pif.mem_reg = 5'd0;
    lit("fwd r0 never", S_FA, 0);
    tick();
    pif.idex_rs = 5'd5; pif.ex_reg = 5'd5; pif.mem_reg = 5'd5; pif.ex_forward = 1'b0;
    pif.idex_rt = 5'd5;
    lit("fwd memwb only", S_FA, 2);
    lit("fwd_b memwb only", S_FB, 2);
    tick();

    // Load-use: one bubble, then the MEM/WB forward.
    idle_inputs();
    pif.ex_forward = 1'b1; pif.ex_is_load = 1'b1; pif.ex_reg = 5'd8; pif.idex_rt = 5'd8;
    lit("lu pc_en", S_PC, 0);
    lit("lu idex_en", S_IDEX, 0);
    lit("lu exmem_flush", S_EXF, 1);
    lit("lu memwb_en", S_MEMWB, 1);
    lit("lu bubble before", S_BUB, 0);
    tick();
    idle_inputs();
    pif.idex_rt = 5'd8; pif.mem_reg = 5'd8; pif.mem_forward = 1'b1;
    lit("lu consumer fwd_b", S_FB, 2);
    lit("lu bubble after", S_BUB, 1);
    lit("lu pc resumes", S_PC, 1);
    tick();

    // Data-memory wait across a pending branch.
    idle_inputs();
    pif.mem_dreq = 1'b1; pif.branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      lit("dwait pc_en", S_PC, 0);
      lit("dwait memwb_en", S_MEMWB, 0);
      lit("dwait no flush", S_IFF, 0);
      tick();
    end
    pif.dhit = 1'b1;
    lit("dwait stall_cnt", S_STALL, 3);
    lit("dhit pc_en", S_PC, 1);
    lit("dhit ifid_flush", S_IFF, 1);
    lit("dhit idex_flush", S_IDF, 1);
    tick();
    idle_inputs();
    lit("after dwait pc_en", S_PC, 1);
    lit("after dwait stall_cnt", S_STALL, 3);
    tick();

    // Instruction cache miss, then with a taken branch.
    pif.ihit = 1'b0;
    lit("imiss pc_en", S_PC, 0);
    lit("imiss ifid_flush", S_IFF, 1);
    lit("imiss idex_en", S_IDEX, 1);
    tick();
    pif.branch_taken = 1'b1;
    lit("imiss+br pc_en", S_PC, 1);
    lit("imiss+br idex_flush", S_IDF, 1);
    tick();

    // Halt, then reset out of it.
    idle_inputs();
    pif.wb_halt = 1'b1;
    lit("halt not yet", S_HALT, 0);
    lit("halt cycle pc_en", S_PC, 1);
    tick();
    pif.wb_halt = 1'b0;
    pif.idex_rs = 5'd5; pif.ex_reg = 5'd5; pif.ex_forward = 1'b1;
    lit("halted", S_HALT, 1);
    lit("halted pc_en", S_PC, 0);
    lit("halted memwb_en", S_MEMWB, 0);
    lit("halted fwd_a", S_FA, 0);
    tick();
    pif.mem_dreq = 1'b1;
    lit("halted stays", S_HALT, 1);
    tick();
    lit("halted no stall count", S_STALL, 3);
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    idle_inputs();
    lit("reset clears halt", S_HALT, 0);
    lit("reset clears stall", S_STALL, 0);
    lit("reset clears bubble", S_BUB, 0);
    lit("reset run pc_en", S_PC, 1);
    tick();

    // Reset aborts a data-memory wait.
    pif.mem_dreq = 1'b1;
    tick();
    tick();
    lit("abort stall_cnt", S_STALL, 2);
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    pif.mem_dreq = 1'b0;
    lit("abort dwait pc_en", S_PC, 1);
    tick();

    // Counter saturation.
    pif.mem_dreq = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    pif.dhit = 1'b1;
    lit("stall saturates", S_STALL, CMAX);
    tick();

    // Mixed traffic over a small register range so matches are frequent.
    for (int i = 0; i < 150; i++) begin
      pif.idex_rs      = 5'($urandom_range(0, 3));
      pif.idex_rt      = 5'($urandom_range(0, 3));
      pif.ex_reg       = 5'($urandom_range(0, 3));
      pif.mem_reg      = 5'($urandom_range(0, 3));
      pif.ex_forward   = 1'($urandom_range(0, 1));
      pif.ex_is_load   = 1'($urandom_range(0, 1));
      pif.mem_forward  = 1'($urandom_range(0, 1));
      pif.mem_dreq     = ($urandom_range(0, 3) == 0);
      pif.dhit         = 1'($urandom_range(0, 1));
      pif.ihit         = ($urandom_range(0, 3) != 0);
      pif.branch_taken = ($urandom_range(0, 4) == 0);
      pif.wb_halt      = (i == 140);
      tick();
    end

    @(negedge CLK);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
